// File: rtl/uart_receiver.sv
// uart_receiver
//   Oversampling UART receiver. The asynchronous rx_i line is synchronized,
//   a falling edge starts a frame, and each bit is sampled near its middle
//   using a 16x sample_i strobe. The frame has 5-8 data bits, optional
//   even/odd parity and 1 or 2 stop bits. Each character is delivered as a
//   one-cycle valid_o pulse together with its error flags.
//
// Handshake: valid_o is a one-cycle strobe with no ready/backpressure. The
//   consumer must take data_o/parity_err_o/frame_err_o in the cycle valid_o
//   is high. They also stay unchanged until the next valid_o.
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   rx_i           serial line, idle high, asynchronous to clk_i
//   sample_i       16x-baud strobe, one clk_i cycle wide
//   data_bits_i    00=5, 01=6, 10=7, 11=8 data bits
//   parity_en_i    parity bit present after the data bits
//   parity_odd_i   1 = odd parity, 0 = even parity
//   stop_bits_i    0 = one stop bit, 1 = two stop bits
//   data_o         received character, right-aligned, unused MSBs zero
//   valid_o        one-cycle pulse per received character
//   parity_err_o   parity mismatch for the character in data_o
//   frame_err_o    a stop bit of that character was sampled low
//   busy_o         receiver is inside a frame
//
// The FSM state is held in state_q (type state_e) for debug visibility.

`timescale 1ns/1ps

module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  input  logic       sample_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       stop_bits_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Synchronizer and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   fall_edge;

  // Counters
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       tick_last;

  // Frame datapath
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       perr_acc_q, perr_acc_d;
  logic       ferr_acc_q, ferr_acc_d;

  // Configuration latched at the start edge
  logic [1:0] cfg_bits_q, cfg_bits_d;
  logic       cfg_par_en_q, cfg_par_en_d;
  logic       cfg_odd_q, cfg_odd_d;
  logic       cfg_stop2_q, cfg_stop2_d;

  // Output registers
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign fall_edge = rx_prev_q & ~rx_s;
  // 16th strobe of a bit period: the sample point for data/parity/stop bits,
  // which lie a whole bit after the mid-start sample.
  assign tick_last = sample_i && (tick_q == 4'd15);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q       <= '1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      tick_q       <= 4'd0;
      bit_q        <= 3'd0;
      shreg_q      <= 8'd0;
      par_q        <= 1'b0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      cfg_bits_q   <= 2'd0;
      cfg_par_en_q <= 1'b0;
      cfg_odd_q    <= 1'b0;
      cfg_stop2_q  <= 1'b0;
      data_q       <= 8'd0;
      valid_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q    <= rx_s;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      cfg_bits_q   <= cfg_bits_d;
      cfg_par_en_q <= cfg_par_en_d;
      cfg_odd_q    <= cfg_odd_d;
      cfg_stop2_q  <= cfg_stop2_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    cfg_bits_d   = cfg_bits_q;
    cfg_par_en_d = cfg_par_en_q;
    cfg_odd_d    = cfg_odd_q;
    cfg_stop2_d  = cfg_stop2_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    perr_d       = perr_q;
    ferr_d       = ferr_q;

    // The strobe is ignored in IDLE, so a strobe coinciding with the start
    // edge detection does not count toward the mid-start sample.
    if (sample_i && (state_q != S_IDLE)) begin
      tick_d = tick_q + 4'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (fall_edge) begin
          state_d      = S_START;
          tick_d       = 4'd0;
          bit_d        = 3'd0;
          shreg_d      = 8'd0;
          par_d        = 1'b0;
          perr_acc_d   = 1'b0;
          ferr_acc_d   = 1'b0;
          cfg_bits_d   = data_bits_i;
          cfg_par_en_d = parity_en_i;
          cfg_odd_d    = parity_odd_i;
          cfg_stop2_d  = stop_bits_i;
        end
      end

      S_START: begin
        if (sample_i && (tick_q == 4'd7)) begin
          tick_d  = 4'd0;
          bit_d   = 3'd0;
          // A high line at mid-start means the edge was a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (tick_last) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          par_d   = par_q ^ rx_s;
          // Last data bit index is N-1 = 4 + data_bits.
          if (bit_q == {1'b1, cfg_bits_q}) begin
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = cfg_par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (tick_last) begin
          perr_acc_d = ((par_q ^ rx_s) != cfg_odd_q);
          tick_d     = 4'd0;
          bit_d      = 3'd0;
          state_d    = S_STOP;
        end
      end

      S_STOP: begin
        if (tick_last) begin
          if (cfg_stop2_q && (bit_q == 3'd0)) begin
            // First of two stop bits; the tick counter wraps to 0 by itself.
            bit_d      = 3'd1;
            ferr_acc_d = ferr_acc_q | ~rx_s;
          end else begin
            // Return to IDLE mid-stop-bit so a following start edge is seen.
            state_d = S_IDLE;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            valid_d = 1'b1;
            // Right-align: shift by 8-N = 3 - data_bits = ~data_bits.
            data_d  = shreg_q >> ~cfg_bits_q;
            perr_d  = perr_acc_q;
            ferr_d  = ferr_acc_q | ~rx_s;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = 4'd0;
        bit_d   = 3'd0;
      end
    endcase
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: table of directed frames, randomized frames
// checked against a character-level model, and hand-written sequences for
// break, glitch, back-to-back frames and mid-frame reset.

`timescale 1ns/1ps

module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  // Clock / reset
  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       rx_i;
  logic       sample_i;
  logic [1:0] data_bits_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       stop_bits_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .rx_i         (rx_i),
    .sample_i     (sample_i),
    .data_bits_i  (data_bits_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop_bits_i  (stop_bits_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  // 16x strobe: one pulse every 4 clocks
  initial begin
    int cnt;
    cnt      = 0;
    sample_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cnt      = (cnt + 1) % 4;
      sample_i = (cnt == 0);
    end
  end

  // Scoreboard: {data[7:0], parity_err, frame_err}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int n_vec = 0;
  int n_err = 0;

  always @(negedge clk_i) begin
    if (valid_o) obs_q.push_back({data_o, parity_err_o, frame_err_o});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Character-level reference: mask to N bits, parity over the N bits plus
  // the parity bit, frame error if any stop bit is low.
  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] db,
                                       input logic pen, input logic podd, input logic s2,
                                       input logic pbit, input logic st1, input logic st2);
    int n;
    int mask;
    logic [7:0] c;
    logic pe;
    logic fe;
    n    = 5 + int'(db);
    mask = (1 << n) - 1;
    c    = d & 8'(mask);
    pe   = pen && ((($countones(c) + int'(pbit)) % 2) != int'(podd));
    fe   = !st1 || (s2 && !st2);
    return {c, pe, fe};
  endfunction

  task automatic hold_bit(input logic v);
    rx_i = v;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic pen,
                            input logic podd, input logic s2, input logic pbit,
                            input logic st1, input logic st2, input bit scramble);
    int n;
    n            = 5 + int'(db);
    data_bits_i  = db;
    parity_en_i  = pen;
    parity_odd_i = podd;
    stop_bits_i  = s2;
    rx_i         = 1'b0;
    repeat (16) @(negedge clk_i);
    if (scramble) begin
      data_bits_i  = 2'($urandom_range(0, 3));
      parity_en_i  = 1'($urandom_range(0, 1));
      parity_odd_i = 1'($urandom_range(0, 1));
      stop_bits_i  = 1'($urandom_range(0, 1));
    end
    repeat (BIT_CLKS - 16) @(negedge clk_i);
    for (int i = 0; i < n; i++) hold_bit(d[i]);
    if (pen) hold_bit(pbit);
    hold_bit(st1);
    if (s2) hold_bit(st2);
    rx_i = 1'b1;
  endtask

  task automatic check_pending(input string name);
    logic [9:0] e;
    logic [9:0] o;
    repeat (16) @(negedge clk_i);
    compare({name, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      compare({name, "_data"}, o[9:2], e[9:2]);
      compare({name, "_perr"}, o[1], e[1]);
      compare({name, "_ferr"}, o[0], e[0]);
    end
    compare({name, "_busy"}, busy_o, 1'b0);
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    string      name;
    logic [7:0] d;
    logic [1:0] db;
    logic       pen;
    logic       podd;
    logic       s2;
    logic       pbit;
    logic       st1;
    logic       st2;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int busy_cnt;

    vecs[0] = '{"8n1_a5",      8'hA5, 2'b11, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
    vecs[1] = '{"7e1_41_p0",   8'h41, 2'b10, 1, 0, 0, 0, 1, 1, 8'h41, 0, 0};
    vecs[2] = '{"7e1_41_p1",   8'h41, 2'b10, 1, 0, 0, 1, 1, 1, 8'h41, 1, 0};
    vecs[3] = '{"8n1_3c_stop", 8'h3C, 2'b11, 0, 0, 0, 0, 0, 1, 8'h3C, 0, 1};
    vecs[4] = '{"8n2_f0_st2",  8'hF0, 2'b11, 0, 0, 1, 0, 1, 0, 8'hF0, 0, 1};
    vecs[5] = '{"8n2_c3_st1",  8'hC3, 2'b11, 0, 0, 1, 0, 0, 1, 8'hC3, 0, 1};
    vecs[6] = '{"5n1_3f",      8'h3F, 2'b00, 0, 0, 0, 0, 1, 1, 8'h1F, 0, 0};
    vecs[7] = '{"6o2_2a",      8'h2A, 2'b01, 1, 1, 1, 0, 1, 1, 8'h2A, 0, 0};
    vecs[8] = '{"8o1_ff_bad",  8'hFF, 2'b11, 1, 1, 0, 0, 1, 1, 8'hFF, 1, 0};

    rst_n_i      = 1'b0;
    rx_i         = 1'b1;
    data_bits_i  = 2'b11;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop_bits_i  = 1'b0;
    repeat (5) @(negedge clk_i);
    compare("reset_data",  data_o, 8'h00);
    compare("reset_valid", valid_o, 1'b0);
    compare("reset_perr",  parity_err_o, 1'b0);
    compare("reset_ferr",  frame_err_o, 1'b0);
    compare("reset_busy",  busy_o, 1'b0);
    rst_n_i = 1'b1;
    repeat (10) @(negedge clk_i);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe});
      send_frame(vecs[i].d, vecs[i].db, vecs[i].pen, vecs[i].podd, vecs[i].s2,
                 vecs[i].pbit, vecs[i].st1, vecs[i].st2, 1'b0);
      check_pending(vecs[i].name);
    end

    // Break: line low for 20 bit times gives one all-zero framed-error char
    data_bits_i = 2'b11;
    parity_en_i = 1'b0;
    stop_bits_i = 1'b0;
    exp_q.push_back({8'h00, 1'b0, 1'b1});
    rx_i = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    check_pending("break");
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 2'b11, 0, 0, 0, 0, 1, 1, 1'b0);
    check_pending("after_break");

    // Glitch: low for 5 strobes, then high
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      rx_i = (i < 20) ? 1'b0 : 1'b1;
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
    end
    compare("glitch_busy_min", busy_cnt >= 29, 1'b1);
    compare("glitch_busy_max", busy_cnt <= 32, 1'b1);
    check_pending("glitch");

    // Back-to-back frames with one stop bit
    exp_q.push_back({8'h01, 1'b0, 1'b0});
    exp_q.push_back({8'h80, 1'b0, 1'b0});
    send_frame(8'h01, 2'b11, 0, 0, 0, 0, 1, 1, 1'b0);
    send_frame(8'h80, 2'b11, 0, 0, 0, 0, 1, 1, 1'b0);
    check_pending("b2b");

    // Reset in the middle of data bit 3 of 0xFF
    data_bits_i = 2'b11;
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(1'b1);
    rx_i = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    compare("midrst_data",  data_o, 8'h00);
    compare("midrst_valid", valid_o, 1'b0);
    compare("midrst_perr",  parity_err_o, 1'b0);
    compare("midrst_ferr",  frame_err_o, 1'b0);
    compare("midrst_busy",  busy_o, 1'b0);
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (20) @(negedge clk_i);
    obs_q.delete();
    exp_q.push_back({8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 2'b11, 0, 0, 0, 0, 1, 1, 1'b0);
    check_pending("after_rst");

    // Randomized frames; config inputs are scrambled mid-frame
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      logic [1:0] db;
      logic pen, podd, s2, pbit, st1, st2;
      d    = 8'($urandom_range(0, 255));
      db   = 2'($urandom_range(0, 3));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      s2   = 1'($urandom_range(0, 1));
      pbit = 1'($urandom_range(0, 1));
      st1  = ($urandom_range(0, 5) != 0);
      st2  = ($urandom_range(0, 5) != 0);
      exp_q.push_back(model(d, db, pen, podd, s2, pbit, st1, st2));
      send_frame(d, db, pen, podd, s2, pbit, st1, st2, 1'b1);
      check_pending("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
